scan_responder: RTL and testbench
=================================

SCAN_RESPONDER -- requirements
Module: scan_responder

Interface
REQ-001 Parameter CHAIN_LEN, default 160, SHALL set the total scan chain length in bits.
REQ-002 Parameter SCAN_KEY, default 16'hBFF9, SHALL set the expected key value in chain bits [CHAIN_LEN-1 -: 16].
REQ-003 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 scan_enable_in  input  1  SHALL be 1 to request shifting, already de-inverted by top level.
REQ-006 scan_in  input  1  SHALL be the serial data in, MSB of frame first.
REQ-007 scan_out  output  1  SHALL be chain[CHAIN_LEN-1] while shifting, otherwise halt_in.
REQ-008 halt_in  input  1  SHALL be the core halt flag.
REQ-009 capture_valid_in  input  1  SHALL qualify capture_data_in.
REQ-010 capture_data_in  input  CHAIN_LEN  SHALL be the parallel core image to capture.
REQ-011 update_valid_out  output  1  SHALL be a one-cycle pulse marking a complete loaded frame.
REQ-012 update_data_out  output  CHAIN_LEN  SHALL be the parallel chain contents.
REQ-013 frame_err_out  output  1  SHALL be a sticky flag for a short or long frame.
REQ-014 key_ok_out  output  1  SHALL report the key comparison of the last good frame.

Function
REQ-015 States SHALL be IDLE, SHIFT and UPDATE.
REQ-016 IDLE: if capture_valid_in, chain SHALL load capture_data_in each cycle; scan_enable_in=1 SHALL move the block to SHIFT and perform the first shift in the same cycle.
REQ-017 Each shift SHALL be chain <= {chain[CHAIN_LEN-2:0], scan_in}; the pre-shift chain[CHAIN_LEN-1] SHALL be presented on scan_out before that edge.
REQ-018 Bit counter SHALL count shifts from 0 and saturate at CHAIN_LEN+1.
REQ-019 SHIFT with scan_enable_in=0: count==CHAIN_LEN SHALL go to UPDATE; any other count SHALL set frame_err_out, go to IDLE and produce no update pulse.
REQ-020 UPDATE SHALL assert update_valid_out for exactly one cycle, register key_ok_out, then return to IDLE.
REQ-021 Capture SHALL be ignored in SHIFT and UPDATE; scan_enable_in SHALL be ignored in UPDATE.
REQ-022 frame_err_out SHALL clear only on reset or on the next good update.
REQ-023 update_data_out SHALL track the chain continuously, so a consumer must sample it only with update_valid_out.

Reset
REQ-024 On rst_in=1: state SHALL go to IDLE, count to 0, chain to 0.
REQ-025 On rst_in=1: update_valid_out, frame_err_out and key_ok_out SHALL be 0, and scan_out SHALL follow halt_in.
REQ-026 rst_in SHALL override all simultaneous events; reset during SHIFT SHALL abort with no update and no error.

Configuration
REQ-027 With SCAN_KEY_EN defined, key_ok_out SHALL be (chain[CHAIN_LEN-1 -: 16]==SCAN_KEY), registered in UPDATE.
REQ-028 Without SCAN_KEY_EN, key_ok_out SHALL be tied 1 and no comparator SHALL be synthesised.

Structure
REQ-029 Package scan_pkg SHALL hold the state enum, CHAIN_LEN default, SCAN_KEY default and field offsets: STATE[2:0], PC[7:3], IR[15:8], ACC[23:16], MEM[n] at 31+8n, KEY top 16 bits.
REQ-030 The bit counter SHALL be a sub-module, scan_bit_counter, with saturation and clear inputs.

Verification
REQ-031 Reset, then shift 160 bits with state=001, PC=1, ACC=01, MEM[0..4]=E0..E4, key=BFF9 -> one update pulse, update_data_out matches the frame, key_ok_out=1, frame_err_out=0.
REQ-032 Same frame with key 0xF3E3 -> update pulse present; key_ok_out=0 with SCAN_KEY_EN defined, 1 without it.
REQ-033 Deassert scan_enable_in after 100 shifts -> no update pulse, frame_err_out=1; a following good 160-bit frame clears it.
REQ-034 Capture image with ACC=0x0B, then shift 160 bits with scan_in=0 -> bits 23:16 of the unloaded stream equal 0x0B, MSB-first order preserved.
REQ-035 halt_in=1 while idle -> scan_out=1; during shift scan_out follows the chain MSB regardless of halt_in.
REQ-036 Assert rst_in at shift 50 -> state IDLE, chain 0, no update pulse, frame_err_out=0.

Source files
------------

// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan responder: FSM state encoding, default
// chain length and key, and the bit offsets of the fields carried in a frame.
//
// Frame layout (bit 0 is the last bit shifted in):
//   STATE  [2:0]
//   PC     [7:3]
//   IR     [15:8]
//   ACC    [23:16]
//   MEM[n] [31+8n -: 8]
//   KEY    top 16 bits of the chain
// -----------------------------------------------------------------------------
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } scan_state_e;

    localparam int          CHAIN_LEN_DEF = 160;
    localparam logic [15:0] SCAN_KEY_DEF  = 16'hBFF9;

    localparam int STATE_LSB = 0;
    localparam int STATE_W   = 3;
    localparam int PC_LSB    = 3;
    localparam int PC_W      = 5;
    localparam int IR_LSB    = 8;
    localparam int IR_W      = 8;
    localparam int ACC_LSB   = 16;
    localparam int ACC_W     = 8;
    localparam int MEM_W     = 8;
    localparam int KEY_W     = 16;

    // MSB position of memory byte n within the frame.
    function automatic int mem_msb(input int n);
        return 31 + 8 * n;
    endfunction

endpackage

// File: rtl/scan_bit_counter.sv
// -----------------------------------------------------------------------------
// scan_bit_counter
// Counts shift operations and saturates at MAX_COUNT.  A clear and an
// increment in the same cycle yield 1, so the first shift of a frame
// (taken while the FSM is still leaving IDLE) is counted.
//
// Ports:
//   clk_in     clock
//   rst_in     synchronous active-high reset
//   clr_in     return the count to zero
//   inc_in     count one shift
//   count_out  current count
// -----------------------------------------------------------------------------
module scan_bit_counter #(
    parameter  int MAX_COUNT = 161,
    localparam int W         = $clog2(MAX_COUNT + 1)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clr_in,
    input  logic         inc_in,
    output logic [W-1:0] count_out
);

    localparam logic [W-1:0] SAT = W'(MAX_COUNT);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else if (clr_in) begin
            count_q <= inc_in ? W'(1) : '0;
        end else if (inc_in && (count_q != SAT)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/scan_responder.sv
// -----------------------------------------------------------------------------
// scan_responder
// Serial scan-chain responder. A core image can be captured into the chain
// while idle, shifted out MSB first while a new frame is shifted in, and a
// frame of exactly CHAIN_LEN bits raises a one-cycle update pulse. Short or
// long frames set a sticky error that clears on the next good update.
//
// Build option: define SCAN_KEY_EN to compare the top 16 chain bits against
// SCAN_KEY at each update; otherwise key_ok_out is tied high.
//
// Ports:
//   clk_in            clock
//   rst_in            synchronous active-high reset
//   scan_enable_in    request shifting
//   scan_in           serial data in, MSB of frame first
//   scan_out          chain MSB while shifting, otherwise halt_in
//   halt_in           core halt flag
//   capture_valid_in  load capture_data_in into the chain while idle
//   capture_data_in   parallel core image
//   update_valid_out  one-cycle pulse on a complete frame
//   update_data_out   live chain contents (sample with update_valid_out)
//   frame_err_out     sticky short/long frame flag
//   key_ok_out        key match of the last good frame
// -----------------------------------------------------------------------------
module scan_responder
    import scan_pkg::*;
#(
    parameter int          CHAIN_LEN = CHAIN_LEN_DEF,
    parameter logic [15:0] SCAN_KEY  = SCAN_KEY_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 scan_enable_in,
    input  logic                 scan_in,
    output logic                 scan_out,
    input  logic                 halt_in,
    input  logic                 capture_valid_in,
    input  logic [CHAIN_LEN-1:0] capture_data_in,
    output logic                 update_valid_out,
    output logic [CHAIN_LEN-1:0] update_data_out,
    output logic                 frame_err_out,
    output logic                 key_ok_out
);

    localparam int            CW       = $clog2(CHAIN_LEN + 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(CHAIN_LEN);

    scan_state_e          state_q;
    logic [CHAIN_LEN-1:0] chain_q;
    logic                 update_valid_q;
    logic                 frame_err_q;
    logic [CW-1:0]        bit_cnt;
    logic                 shift_now;
    logic                 cnt_clr;

    // A shift happens on the IDLE->SHIFT edge as well as inside SHIFT.
    assign shift_now = !rst_in && scan_enable_in &&
                       ((state_q == ST_IDLE) || (state_q == ST_SHIFT));
    assign cnt_clr   = (state_q == ST_IDLE);

    scan_bit_counter #(
        .MAX_COUNT (CHAIN_LEN + 1)
    ) u_bit_cnt (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (cnt_clr),
        .inc_in    (shift_now),
        .count_out (bit_cnt)
    );

`ifdef SCAN_KEY_EN
    logic key_ok_q;
`endif

    // Update pulse and key result are registered on entry to UPDATE, so both
    // are visible during the single UPDATE cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            chain_q        <= '0;
            update_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
`ifdef SCAN_KEY_EN
            key_ok_q       <= 1'b0;
`endif
        end else begin
            update_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (scan_enable_in) begin
                        state_q <= ST_SHIFT;
                        chain_q <= {chain_q[CHAIN_LEN-2:0], scan_in};
                    end else if (capture_valid_in) begin
                        chain_q <= capture_data_in;
                    end
                end
                ST_SHIFT: begin
                    if (scan_enable_in) begin
                        chain_q <= {chain_q[CHAIN_LEN-2:0], scan_in};
                    end else if (bit_cnt == FULL_CNT) begin
                        state_q        <= ST_UPDATE;
                        update_valid_q <= 1'b1;
                        frame_err_q    <= 1'b0;
`ifdef SCAN_KEY_EN
                        key_ok_q       <= (chain_q[CHAIN_LEN-1 -: KEY_W] == SCAN_KEY);
`endif
                    end else begin
                        state_q     <= ST_IDLE;
                        frame_err_q <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan_out         = shift_now ? chain_q[CHAIN_LEN-1] : halt_in;
    assign update_valid_out = update_valid_q;
    assign update_data_out  = chain_q;
    assign frame_err_out    = frame_err_q;
`ifdef SCAN_KEY_EN
    assign key_ok_out       = key_ok_q;
`else
    assign key_ok_out       = 1'b1;
`endif

endmodule

// File: tb/tb_scan_responder.sv
module tb_scan_responder;
    import scan_pkg::*;

    localparam int N = 160;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         scan_enable_in = 1'b0;
    logic         scan_in = 1'b0;
    logic         scan_out;
    logic         halt_in = 1'b0;
    logic         capture_valid_in = 1'b0;
    logic [N-1:0] capture_data_in = '0;
    logic         update_valid_out;
    logic [N-1:0] update_data_out;
    logic         frame_err_out;
    logic         key_ok_out;

    typedef struct {
        logic [N-1:0] data;
        logic         key_ok;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp   = 0;
    int           n_mis   = 0;
    int           n_pulse = 0;
    logic [N-1:0] model   = '0;

    scan_responder dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .scan_enable_in   (scan_enable_in),
        .scan_in          (scan_in),
        .scan_out         (scan_out),
        .halt_in          (halt_in),
        .capture_valid_in (capture_valid_in),
        .capture_data_in  (capture_data_in),
        .update_valid_out (update_valid_out),
        .update_data_out  (update_data_out),
        .frame_err_out    (frame_err_out),
        .key_ok_out       (key_ok_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_key(input logic [15:0] key);
`ifdef SCAN_KEY_EN
        return (key == 16'hBFF9);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [N-1:0] build_frame(input logic [15:0] key, input logic [7:0] acc);
        logic [N-1:0] f;
        f = '0;
        f[STATE_LSB +: STATE_W] = 3'b001;
        f[PC_LSB +: PC_W]       = 5'd1;
        f[ACC_LSB +: ACC_W]     = acc;
        for (int n = 0; n < 5; n++) f[mem_msb(n) -: MEM_W] = 8'hE0 + 8'(n);
        f[N-1 -: KEY_W] = key;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Shift n bits of f, MSB first; records scan_out before each edge.
    task automatic shift_bits(input logic [N-1:0] f, input int n, output logic [N-1:0] so);
        so = '0;
        for (int i = 0; i < n; i++) begin
            scan_enable_in = 1'b1;
            scan_in        = f[N-1-i];
            #1 so[N-1-i]   = scan_out;
            model          = {model[N-2:0], f[N-1-i]};
            @(posedge clk_in);
            #1;
        end
        scan_enable_in = 1'b0;
        scan_in        = 1'b0;
    endtask

    // Scoreboard: every update pulse consumes one expected frame.
    always @(negedge clk_in) begin
        exp_t e;
        if (update_valid_out) begin
            n_pulse++;
            chk("sb_nonempty", N'(sb_q.size() != 0), N'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("upd_data", update_data_out, e.data);
                chk("upd_key_ok", N'(key_ok_out), N'(e.key_ok));
            end
        end
    end

    initial begin
        logic [N-1:0] fa, fb, img, so, exp_so;
        int           pulses_ref;

        fa  = build_frame(16'hBFF9, 8'h01);
        fb  = build_frame(16'hF3E3, 8'h01);
        img = build_frame(16'hBFF9, 8'h0B);

        // Reset state
        halt_in = 1'b1;
        tick(2);
        chk("rst_scan_out_h", N'(scan_out), N'(1));
        chk("rst_upd_valid", N'(update_valid_out), N'(0));
        chk("rst_frame_err", N'(frame_err_out), N'(0));
        chk("rst_upd_data", update_data_out, '0);
`ifdef SCAN_KEY_EN
        chk("rst_key_ok", N'(key_ok_out), N'(0));
`else
        chk("rst_key_ok", N'(key_ok_out), N'(1));
`endif
        halt_in = 1'b0;
        #1 chk("rst_scan_out_l", N'(scan_out), N'(0));
        tick(1);
        rst_in = 1'b0;
        model  = '0;

        // Idle: scan_out mirrors halt_in
        halt_in = 1'b1;
        #1 chk("idle_halt_1", N'(scan_out), N'(1));
        halt_in = 1'b0;
        #1 chk("idle_halt_0", N'(scan_out), N'(0));
        tick(1);

        // Good frame with correct key; halt_in high must not leak onto scan_out
        sb_q.push_back('{data: fa, key_ok: exp_key(16'hBFF9)});
        halt_in = 1'b1;
        exp_so  = model;
        shift_bits(fa, N, so);
        halt_in = 1'b0;
        chk("a_unload", so, exp_so);
        tick(3);
        chk("a_pulses", N'(n_pulse), N'(1));
        chk("a_frame_err", N'(frame_err_out), N'(0));
        chk("a_key_ok", N'(key_ok_out), N'(exp_key(16'hBFF9)));

        // Same frame with wrong key
        sb_q.push_back('{data: fb, key_ok: exp_key(16'hF3E3)});
        exp_so = model;
        shift_bits(fb, N, so);
        chk("b_unload", so, exp_so);
        tick(3);
        chk("b_pulses", N'(n_pulse), N'(2));
        chk("b_key_ok", N'(key_ok_out), N'(exp_key(16'hF3E3)));

        // Short frame: 100 shifts
        pulses_ref = n_pulse;
        shift_bits(fa, 100, so);
        tick(3);
        chk("short_no_pulse", N'(n_pulse), N'(pulses_ref));
        chk("short_err", N'(frame_err_out), N'(1));
        chk("short_chain", update_data_out, model);
        tick(5);
        chk("short_err_sticky", N'(frame_err_out), N'(1));

        // Good frame clears the error
        sb_q.push_back('{data: fa, key_ok: exp_key(16'hBFF9)});
        exp_so = model;
        shift_bits(fa, N, so);
        chk("c_unload", so, exp_so);
        tick(3);
        chk("c_pulses", N'(n_pulse), N'(3));
        chk("c_err_clear", N'(frame_err_out), N'(0));

        // Capture image, then unload it with zeros shifted in
        capture_valid_in = 1'b1;
        capture_data_in  = img;
        tick(1);
        capture_valid_in = 1'b0;
        capture_data_in  = '0;
        model            = img;
        chk("cap_chain", update_data_out, img);
        sb_q.push_back('{data: '0, key_ok: exp_key(16'h0000)});
        shift_bits('0, N, so);
        chk("cap_unload", so, img);
        chk("cap_acc", N'(so[ACC_LSB +: ACC_W]), N'(8'h0B));
        tick(3);
        chk("cap_pulses", N'(n_pulse), N'(4));

        // Reset in the middle of a frame
        pulses_ref = n_pulse;
        shift_bits(fa, 50, so);
        scan_enable_in = 1'b1;
        rst_in         = 1'b1;
        tick(1);
        chk("abort_chain", update_data_out, '0);
        chk("abort_err", N'(frame_err_out), N'(0));
        rst_in         = 1'b0;
        scan_enable_in = 1'b0;
        halt_in        = 1'b1;
        #1 chk("abort_idle", N'(scan_out), N'(1));
        tick(3);
        chk("abort_no_pulse", N'(n_pulse), N'(pulses_ref));
        chk("abort_err_after", N'(frame_err_out), N'(0));
        halt_in = 1'b0;
        model   = '0;

        chk("sb_drained", N'(sb_q.size()), N'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
